universal_shift_reg_sync_re: RTL

- WIDTH-bit universal shift register. Consumes the D flip-flop stage as its storage primitive: one flip-flop per bit, with a 4:1 next-state mux in front of each.
- Supports hold, shift right, shift left and parallel load. Reset is synchronous.
- Sits downstream of the single-bit flip-flop cell. Intended as the register building block for the lab's counter and serial-link exercises.

---
 rtl/universal_shift_reg_sync_re_pkg.sv | 16 +
 rtl/dff_sync_re.sv | 28 ++
 rtl/universal_shift_reg_sync_re.sv | 62 ++++++
 3 files changed

// File: rtl/universal_shift_reg_sync_re_pkg.sv
// Shared mode encodings and default width for the universal shift register.
// Revision 1.0
`default_nettype none

package universal_shift_reg_sync_re_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/dff_sync_re.sv
// Rising-edge D flip-flop with synchronous active-high reset and complement output.
// Revision 1.0
`default_nettype none

module dff_sync_re (
  input  logic D,
  input  logic C,
  input  logic RE,
  output logic Q,
  output logic Qnot
);

  logic q_reg;

  always_ff @(posedge C) begin
    if (RE) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= D;
    end
  end

  assign Q    = q_reg;
  assign Qnot = ~q_reg;

endmodule

`default_nettype wire

// File: rtl/universal_shift_reg_sync_re.sv
// WIDTH-bit universal shift register: hold, shift right, shift left, parallel load.
// Revision 1.0
`default_nettype none

module universal_shift_reg_sync_re
  import universal_shift_reg_sync_re_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             C,
  input  logic             RE,
  input  logic [1:0]       S,
  input  logic             SR_IN,
  input  logic             SL_IN,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot
);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] qn_int;
  logic [WIDTH-1:0] shr_src;
  logic [WIDTH-1:0] shl_src;
  logic             sel_hold;
  logic             sel_shr;
  logic             sel_shl;
  logic             sel_load;

  // One-hot decode of the mode select feeds every per-bit AND-OR mux.
  assign sel_hold = (S == MODE_HOLD);
  assign sel_shr  = (S == MODE_SHR);
  assign sel_shl  = (S == MODE_SHL);
  assign sel_load = (S == MODE_LOAD);

  assign shr_src = {SR_IN, q_int[WIDTH-1:1]};
  assign shl_src = {q_int[WIDTH-2:0], SL_IN};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic d_mux;
    logic d_bit;

    assign d_mux = (sel_hold & q_int[i])
                 | (sel_shr  & shr_src[i])
                 | (sel_shl  & shl_src[i])
                 | (sel_load & P[i]);
    assign d_bit = d_mux & ~RE;

    dff_sync_re u_bit (
      .D    (d_bit),
      .C    (C),
      .RE   (RE),
      .Q    (q_int[i]),
      .Qnot (qn_int[i])
    );
  end

  assign Q    = q_int;
  assign Qnot = qn_int;

endmodule

`default_nettype wire
